// File: rtl/fx_div_seq.sv
// Sequential signed fixed-point divider: one restoring-division quotient bit per cycle,
// truncation toward zero, saturation on overflow and a defined result for a zero divisor.
module fx_div_seq #(
  parameter int WIDTH = 32,
  parameter int QINT  = 16,
  parameter int FRAC  = WIDTH - QINT,
  parameter int ITER  = WIDTH + FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] denom,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] quot,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ITER-1:0]    dq_q, dq_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dmag_q, dmag_d;
  logic               sign_q, sign_d;
  logic               zden_q, zden_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_step;
  logic [ITER-1:0]    q_step;
  logic [WIDTH:0]     sat_res;

  // Magnitude of a two's-complement word; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = v;
    return s[WIDTH-1] ? WIDTH'(-s) : v;
  endfunction

  // Applies the sign to the truncated magnitude and saturates; MSB of the result is the overflow flag.
  function automatic logic [WIDTH:0] round_sat(input logic [ITER-1:0] mag, input logic neg);
    logic big;
    if (!neg) begin
      big = |mag[ITER-1:WIDTH-1];
      return big ? {1'b1, MAX_POS} : {1'b0, mag[WIDTH-1:0]};
    end
    big = (|mag[ITER-1:WIDTH]) || (mag[WIDTH-1] && (|mag[WIDTH-2:0]));
    return big ? {1'b1, MIN_NEG} : {1'b0, WIDTH'(0) - mag[WIDTH-1:0]};
  endfunction

  assign ready_in    = (state_q == IDLE) && rst_n;
  assign valid_out   = valid_q;
  assign quot        = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  // The dividend shifts out of dq MSB-first while quotient bits shift in at the LSB.
  assign trial    = {rem_q, dq_q[ITER-1]};
  assign diff     = trial - {1'b0, dmag_q};
  assign fits     = trial >= {1'b0, dmag_q};
  assign rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step   = {dq_q[ITER-2:0], fits};
  assign sat_res  = round_sat(q_step, sign_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    sign_d  = sign_q;
    zden_d  = zden_q;
    valid_d = valid_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          sign_d  = num[WIDTH-1] ^ denom[WIDTH-1];
          dmag_d  = mag_of(denom);
          dq_d    = ITER'({mag_of(num), {FRAC{1'b0}}});
          rem_d   = '0;
          zden_d  = (denom == '0);
          cnt_d   = (denom == '0) ? '0 : CNT_W'(ITER - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (zden_q) begin
          // A zero divisor spends one cycle here without iterating; sign_q is num's sign.
          quot_d  = sign_q ? MIN_NEG : MAX_POS;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          dq_d  = q_step;
          rem_d = rem_step;
          if (cnt_q == '0) begin
            quot_d  = sat_res[WIDTH-1:0];
            ovf_d   = sat_res[WIDTH];
            dbz_d   = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (ready_out) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      sign_q  <= 1'b0;
      zden_q  <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      sign_q  <= sign_d;
      zden_q  <= zden_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fx_div_seq.sv
// Directed bench for fx_div_seq: hand-computed Q16.16 quotients, latency, flags,
// backpressure, dropped operands and asynchronous reset mid-operation.
module tb_fx_div_seq;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] num;
  logic [31:0] denom;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] quot;
  logic        div_by_zero;
  logic        overflow;

  int n_tests;
  int n_fail;

  fx_div_seq #(.WIDTH(32), .QINT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .num        (num),
    .denom      (denom),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .quot       (quot),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency, optionally hold off the consumer and pulse valid_in mid-CALC.
  task automatic do_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_q,
                       input logic exp_dbz, input logic exp_ovf,
                       input int hold, input bit pulse);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy_in"}, 32'(ready_in), 32'd1);
    valid_in = 1'b1;
    num      = n;
    denom    = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (pulse && lat == 5) begin
        chk({tag, "_rdy_calc"}, 32'(ready_in), 32'd0);
        valid_in = 1'b1;
        num      = 32'h0005_0000;
        denom    = 32'h0000_0000;
      end else begin
        valid_in = 1'b0;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quot"}, quot, exp_q);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_vld"}, 32'(valid_out), 32'd1);
      chk({tag, "_hold_q"}, quot, exp_q);
      chk({tag, "_hold_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, exp_dbz, exp_ovf});
      chk({tag, "_hold_rdy"}, 32'(ready_in), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_rdy_hs"}, 32'(ready_in), 32'd0);
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    chk({tag, "_vld_clr"}, 32'(valid_out), 32'd0);
    chk({tag, "_rdy_back"}, 32'(ready_in), 32'd1);
  endtask

  initial begin
    bit seen;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    num       = '0;
    denom     = '0;
    #12;
    chk("rst_vld", 32'(valid_out), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    chk("rst_rdy", 32'(ready_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("div3_2",    32'h0003_0000, 32'h0002_0000, 48, 32'h0001_8000, 1'b0, 1'b0, 0, 1'b0);
    do_op("divm1_3",   32'hFFFF_0000, 32'h0003_0000, 48, 32'hFFFF_AAAB, 1'b0, 1'b0, 0, 1'b0);
    do_op("div1_3",    32'h0001_0000, 32'h0003_0000, 48, 32'h0000_5555, 1'b0, 1'b0, 0, 1'b0);
    do_op("divm7p5_2", 32'hFFF8_8000, 32'h0002_0000, 48, 32'hFFFC_4000, 1'b0, 1'b0, 0, 1'b0);
    do_op("dbz_pos",   32'h0005_0000, 32'h0000_0000, 1,  32'h7FFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
    do_op("dbz_neg",   32'hFFFF_0000, 32'h0000_0000, 1,  32'h8000_0000, 1'b1, 1'b0, 0, 1'b0);
    do_op("ovf_pos",   32'h7FFF_0000, 32'h0000_8000, 48, 32'h7FFF_FFFF, 1'b0, 1'b1, 0, 1'b0);
    do_op("ovf_minm1", 32'h8000_0000, 32'hFFFF_0000, 48, 32'h7FFF_FFFF, 1'b0, 1'b1, 0, 1'b0);
    do_op("min_div1",  32'h8000_0000, 32'h0001_0000, 48, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0);
    do_op("ovf_neg",   32'h8000_0000, 32'h0000_8000, 48, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
    do_op("bp",        32'h0003_0000, 32'h0002_0000, 48, 32'h0001_8000, 1'b0, 1'b0, 10, 1'b1);

    // The operand pulsed during CALC must not have started a second operation.
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (valid_out) seen = 1'b1;
    end
    chk("bp_dropped", 32'(seen), 32'd0);

    // Reset 20 cycles into CALC.
    @(negedge clk);
    valid_in = 1'b1;
    num      = 32'h0003_0000;
    denom    = 32'h0002_0000;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(valid_out), 32'd0);
    chk("mid_rst_quot", quot, 32'd0);
    chk("mid_rst_rdy", 32'(ready_in), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (valid_out) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    do_op("after_rst", 32'h0003_0000, 32'h0002_0000, 48, 32'h0001_8000, 1'b0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
